sy_ppl_fetch_ctrl: RTL and testbench
====================================

// Module: sy_ppl_fetch_ctrl
// PURPOSE
//   Sequences instruction fetch between the I-cache and the front-end instruction buffer.
//   Issues aligned fetch requests while the buffer can accept data and tracks outstanding requests.
//   On a redirect it flushes the buffer and silently drops stale in-flight responses, so only
//   responses for the new path reach the buffer. Stops fetching after a page-fault response.
// PARAMETERS
//   AWTH            64     address width
//   FETCH_BYTES     8      bytes per fetch block (power of 2); request addresses are aligned to this
//   MAX_OUTSTANDING 2      max in-flight I-cache requests (>=1)
//   BOOT_ADDR       'h80000000  first fetch PC after reset
// PORTS
//   clk_i              in   1     clock
//   rst_i              in   1     asynchronous, active-high reset
//   redirect_i         in   1     pipeline redirect (branch/exception/fence)
//   redirect_pc_i      in   AWTH  new fetch PC, valid with redirect_i
//   ibuf_ready_i       in   1     instruction buffer has room
//   ibuf_flush_o       out  1     flush to instruction buffer
//   ibuf_push_o        out  1     forward current I-cache response into the buffer
//   ibuf_ex_o          out  1     forwarded response carries instruction page fault
//   icache_req_valid_o out  1     fetch request valid
//   icache_req_addr_o  out  AWTH  fetch request address
//   icache_req_ready_i in   1     I-cache accepts request
//   icache_rsp_valid_i in   1     in-order response valid (always accepted)
//   icache_rsp_ex_i    in   1     response page fault
//   outstanding_o      out  $clog2(MAX_OUTSTANDING+1)  in-flight request count
// BEHAVIOUR
//   Reset (async, rst_i=1): state=BOOT, pc=BOOT_ADDR, outstanding=0, drop_cnt=0.
//     Outputs during reset: req_valid=0, push=0, ex=0, flush=0, req_addr=BOOT_ADDR.
//   FSM BOOT -> RUN after 1 cycle; ibuf_flush_o=1 in BOOT and no requests are issued.
//     RUN -> HALT on a forwarded response with ex=1.
//     HALT -> RUN on redirect_i.
//     In any state, redirect_i goes to RUN; reset wins over everything.
//   ibuf_flush_o = (state==BOOT) | redirect_i.
//   icache_req_valid_o = state==RUN & ibuf_ready_i & !redirect_i & outstanding<MAX_OUTSTANDING.
//     Combinational from registered state/count, ready and redirect. A response in the same
//     cycle does not free a slot.
//   icache_req_addr_o = pc & ~(FETCH_BYTES-1). On handshake, pc <= that address + FETCH_BYTES,
//     wrapping modulo 2^AWTH.
//   outstanding: +1 on request handshake, -1 on response. Both in the same cycle -> unchanged.
//     A response with outstanding==0 is ignored (assertion).
//   Drop rule: a response is stale if drop_cnt!=0, or if it arrives in a redirect cycle, or if
//     state==HALT. A stale response is consumed (outstanding--), not pushed, and drop_cnt-- when
//     drop_cnt!=0.
//   ibuf_push_o = rsp_valid & !stale; ibuf_ex_o = push & rsp_ex.
//   On redirect_i:
//     pc <= redirect_pc_i (unaligned allowed; the buffer selects the instruction by PC).
//     drop_cnt <= outstanding minus (1 if a response arrives this cycle). This equals every
//       request still in flight after this cycle.
//     No request is issued in the redirect cycle.
//     Requests may be issued in the next cycle even while drop_cnt!=0; in-order responses
//       guarantee the first drop_cnt responses are the stale ones.
//   Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
//   Latency: a redirect in cycle N produces its first request in N+1, if the buffer is ready
//     and a slot is free.
// TESTING
//   1 Reset release, ibuf_ready=1, req_ready=1 -> flush in BOOT cycle; requests 0x80000000,
//     0x80000008; then stall at outstanding=2 until a response arrives.
//   2 Two requests in flight, redirect to 0x1006 -> flush=1, no req that cycle.
//     Next two responses are dropped (push=0); the next request addr is 0x1000, and its
//     response is pushed.
//   3 Redirect coincident with one response, outstanding=2 -> that response is dropped,
//     drop_cnt=1, outstanding=1 next cycle.
//   4 Response with ex=1 -> push=1, ex=1; state HALT, no further requests, and a pending
//     response is dropped; redirect to 0x2000 resumes fetch at 0x2000.
//   5 ibuf_ready=0 for 10 cycles -> no requests; outstanding drains to 0; pc is held.
//   6 pc=2^AWTH-8 -> request at 0xFFFF_FFFF_FFFF_FFF8, then 0x0 (wrap); async reset
//     mid-flight -> all outputs reset immediately.

Source files
------------

// File: rtl/sy_ppl_fetch_ctrl.sv
// sy_ppl_fetch_ctrl: instruction fetch sequencer between I-cache and instruction buffer
//   clk_i/rst_i                   clock, async active-high reset
//   redirect_i/redirect_pc_i      pipeline redirect and new fetch PC
//   ibuf_ready_i                  buffer has room
//   ibuf_flush_o/push_o/ex_o      buffer flush, push of current response, page-fault flag
//   icache_req_valid_o/addr_o     aligned fetch request, icache_req_ready_i accepts it
//   icache_rsp_valid_i/ex_i       in-order response, always consumed
//   outstanding_o                 in-flight request count
module sy_ppl_fetch_ctrl #(
    parameter int AWTH = 64,
    parameter int FETCH_BYTES = 8,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [AWTH-1:0] BOOT_ADDR = 'h80000000
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   redirect_i,
    input  logic [AWTH-1:0]                        redirect_pc_i,
    input  logic                                   ibuf_ready_i,
    output logic                                   ibuf_flush_o,
    output logic                                   ibuf_push_o,
    output logic                                   ibuf_ex_o,
    output logic                                   icache_req_valid_o,
    output logic [AWTH-1:0]                        icache_req_addr_o,
    input  logic                                   icache_req_ready_i,
    input  logic                                   icache_rsp_valid_i,
    input  logic                                   icache_rsp_ex_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
    state_t state, state_nxt;
    logic [AWTH-1:0] pc, pc_nxt;
    logic [CW-1:0] drop_cnt, drop_nxt, out_nxt;
    logic rsp, stale, hs;
    assign icache_req_addr_o = pc & ~AWTH'(FETCH_BYTES - 1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= BOOT;
            pc <= BOOT_ADDR;
            outstanding_o <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            outstanding_o <= out_nxt;
            drop_cnt <= drop_nxt;
        end
    end
    // Stale responses belong to a path abandoned by a redirect; in-order return means
    // the first drop_cnt responses after a redirect are exactly those.
    always_comb begin
        rsp = icache_rsp_valid_i & (outstanding_o != '0);
        stale = (drop_cnt != '0) | redirect_i | (state == HALT);
        ibuf_push_o = rsp & !stale;
        ibuf_ex_o = ibuf_push_o & icache_rsp_ex_i;
        ibuf_flush_o = !rst_i & ((state == BOOT) | redirect_i);
        icache_req_valid_o = (state == RUN) & ibuf_ready_i & !redirect_i
                             & (outstanding_o < CW'(MAX_OUTSTANDING));
        hs = icache_req_valid_o & icache_req_ready_i;
        out_nxt = outstanding_o + CW'(hs) - CW'(rsp);
        drop_nxt = redirect_i ? outstanding_o - CW'(rsp)
                 : (rsp && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
        pc_nxt = redirect_i ? redirect_pc_i
               : hs ? icache_req_addr_o + AWTH'(FETCH_BYTES) : pc;
        state_nxt = (redirect_i || state == BOOT) ? RUN
                  : ibuf_ex_o ? HALT : state;
    end
    a_rsp_with_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        icache_rsp_valid_i |-> outstanding_o != '0);
endmodule

// File: tb/tb_sy_ppl_fetch_ctrl.sv
// tb_sy_ppl_fetch_ctrl: directed self-checking bench for sy_ppl_fetch_ctrl
module tb_sy_ppl_fetch_ctrl;
    logic clk = 0, rst = 1;
    logic redirect = 0, ibuf_ready = 1, req_ready = 1, rsp_valid = 0, rsp_ex = 0;
    logic [63:0] redirect_pc = '0;
    logic flush, push, ex, req_valid;
    logic [63:0] req_addr;
    logic [1:0] outstanding;
    int n_tests = 0, n_fail = 0;
    sy_ppl_fetch_ctrl dut (
        .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .ibuf_ready_i(ibuf_ready), .ibuf_flush_o(flush), .ibuf_push_o(push), .ibuf_ex_o(ex),
        .icache_req_valid_o(req_valid), .icache_req_addr_o(req_addr),
        .icache_req_ready_i(req_ready), .icache_rsp_valid_i(rsp_valid),
        .icache_rsp_ex_i(rsp_ex), .outstanding_o(outstanding)
    );
    always #5 clk = ~clk;
    task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task tick;
        @(posedge clk);
        #1;
    endtask
    initial begin
        rsp_valid = 1;
        #12;
        chk("rst_flush", flush, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_addr", req_addr, 64'h80000000);
        chk("rst_out", outstanding, 0);
        chk("rst_push", push, 0);
        rsp_valid = 0;
        rst = 0;
        #1;
        chk("boot_flush", flush, 1);
        chk("boot_valid", req_valid, 0);
        tick;
        chk("run_flush", flush, 0);
        chk("req0_valid", req_valid, 1);
        chk("req0_addr", req_addr, 64'h80000000);
        tick;
        chk("req1_valid", req_valid, 1);
        chk("req1_addr", req_addr, 64'h80000008);
        tick;
        chk("full_out", outstanding, 2);
        chk("full_valid", req_valid, 0);
        rsp_valid = 1;
        #1;
        chk("rsp_push", push, 1);
        chk("rsp_noslot", req_valid, 0);
        tick;
        rsp_valid = 0;
        #1;
        chk("slot_out", outstanding, 1);
        chk("req2_addr", req_addr, 64'h80000010);
        chk("req2_valid", req_valid, 1);
        tick;
        // redirect with two in flight
        redirect = 1;
        redirect_pc = 64'h1006;
        #1;
        chk("t2_flush", flush, 1);
        chk("t2_noreq", req_valid, 0);
        tick;
        redirect = 0;
        rsp_valid = 1;
        #1;
        chk("t2_drop0", push, 0);
        chk("t2_full", req_valid, 0);
        tick;
        chk("t2_drop1", push, 0);
        chk("t2_req_valid", req_valid, 1);
        chk("t2_req_addr", req_addr, 64'h1000);
        tick;
        req_ready = 0;
        #1;
        chk("t2_out", outstanding, 1);
        chk("t2_push", push, 1);
        tick;
        rsp_valid = 0;
        req_ready = 1;
        #1;
        chk("t2_drained", outstanding, 0);
        chk("t2_next_addr", req_addr, 64'h1008);
        tick;
        tick;
        chk("t3_out2", outstanding, 2);
        // redirect coincident with a response
        redirect = 1;
        redirect_pc = 64'h3000;
        rsp_valid = 1;
        #1;
        chk("t3_push", push, 0);
        chk("t3_flush", flush, 1);
        tick;
        redirect = 0;
        rsp_valid = 0;
        req_ready = 0;
        #1;
        chk("t3_out1", outstanding, 1);
        chk("t3_addr", req_addr, 64'h3000);
        rsp_valid = 1;
        #1;
        chk("t3_drop", push, 0);
        tick;
        rsp_valid = 0;
        req_ready = 1;
        #1;
        chk("t3_out0", outstanding, 0);
        tick;
        tick;
        chk("t4_out2", outstanding, 2);
        // page fault halts fetch
        rsp_valid = 1;
        rsp_ex = 1;
        #1;
        chk("t4_push", push, 1);
        chk("t4_ex", ex, 1);
        tick;
        rsp_valid = 0;
        rsp_ex = 0;
        #1;
        chk("t4_halt_noreq", req_valid, 0);
        chk("t4_out1", outstanding, 1);
        rsp_valid = 1;
        #1;
        chk("t4_halt_drop", push, 0);
        tick;
        rsp_valid = 0;
        redirect = 1;
        redirect_pc = 64'h2000;
        #1;
        chk("t4_flush", flush, 1);
        chk("t4_redir_noreq", req_valid, 0);
        tick;
        redirect = 0;
        #1;
        chk("t4_resume_valid", req_valid, 1);
        chk("t4_resume_addr", req_addr, 64'h2000);
        tick;
        // buffer not ready for 10 cycles
        ibuf_ready = 0;
        rsp_valid = 1;
        #1;
        chk("t5_push", push, 1);
        for (int i = 0; i < 10; i++) begin
            chk("t5_noreq", req_valid, 0);
            tick;
            rsp_valid = 0;
            #1;
        end
        chk("t5_out0", outstanding, 0);
        chk("t5_pc_held", req_addr, 64'h2008);
        ibuf_ready = 1;
        #1;
        chk("t5_valid", req_valid, 1);
        // address wrap
        redirect = 1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        #1;
        chk("t6_noreq", req_valid, 0);
        tick;
        redirect = 0;
        #1;
        chk("t6_addr_top", req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        tick;
        chk("t6_addr_wrap", req_addr, 64'h0);
        chk("t6_wrap_valid", req_valid, 1);
        tick;
        chk("t6_out2", outstanding, 2);
        #2;
        rst = 1;
        rsp_valid = 1;
        #1;
        chk("t6_rst_out", outstanding, 0);
        chk("t6_rst_valid", req_valid, 0);
        chk("t6_rst_addr", req_addr, 64'h80000000);
        chk("t6_rst_flush", flush, 0);
        chk("t6_rst_push", push, 0);
        chk("t6_rst_ex", ex, 0);
        rsp_valid = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
